small_comb_logic_arb: RTL and testbench
=======================================

# small_comb_logic_arb

Round-robin arbiter and sequencer that shares one 8-bit small-combinational-logic transform unit between `N_REQ` requesters. It accepts at most one request per cycle over per-requester valid/ready handshakes and applies the transform. It then presents the result in a registered output stage, tagged with the source requester ID, under its own valid/ready handshake with backpressure. The block sits between the requester ports and the downstream consumer of transformed bytes.

## Interface
- `N_REQ`, default 4: number of requesters, range 2..16.
- `ID_W`, default 2: width of the requester ID, equal to `$clog2(N_REQ)`.
- `CNT_W`, default 16: width of the completed-transfer counter.
- `clk`, input, 1: single clock, all state on its rising edge.
- `resetn`, input, 1: asynchronous, active-low reset.
- `req_valid`, input, `N_REQ`: request i presents data.
- `req_data`, input, `N_REQ*8`: byte of requester i at `[8*i +: 8]`.
- `req_ready`, output, `N_REQ`: request i is accepted this cycle; at most one bit is set.
- `out_valid`, output, 1: result stage holds a valid result.
- `out_data`, output, 8: transformed byte.
- `out_id`, output, `ID_W`: index of the requester that produced `out_data`.
- `out_ready`, input, 1: consumer accepts the result.
- `busy`, output, 1: equal to `out_valid | (|req_valid)`.
- `xfer_cnt`, output, `CNT_W`: count of output handshakes.

## Operation
- Transform f(d), 8 bits in, 8 bits out:
  - o[0] = d[0]
  - o[1] = ~d[1]
  - o[3:2] = d[1:0] ^ d[3:2]
  - o[5:4] = (d[1:0] + d[3:2]) mod 4, carry discarded
  - o[6] = d[6] & d[7]
  - o[7] = d[6] | d[7]
- `load_en = !out_valid | out_ready`. The stage may load whenever it is empty or is being drained in the same cycle.
- Arbitration:
  - Round-robin pointer `ptr`, `ID_W` bits, reset 0.
  - Grant goes to the first i with `req_valid[i]` = 1, searching `ptr`, `ptr+1`, … modulo `N_REQ`.
  - `req_ready[g] = load_en` for the granted index g; all other bits are 0.
  - `req_ready` is combinational from `req_valid`, `ptr`, `out_valid` and `out_ready`. Requesters must not make valid depend on ready.
- On acceptance (`req_valid[g] & req_ready[g]`):
  - `out_data <= f(req_data[g])`, `out_id <= g`, `out_valid <= 1`.
  - `ptr <= (g+1) mod N_REQ`.
- No acceptance:
  - If `out_ready & out_valid`, then `out_valid <= 0`.
  - `ptr` holds.
- Output stage states:
  - EMPTY (`out_valid` = 0) to FULL: on acceptance.
  - FULL to FULL: on drain with a simultaneous accept. The new result replaces the old one with no bubble.
  - FULL to EMPTY: on drain with no accept.
  - FULL held (`out_ready` = 0): `out_data` and `out_id` stay stable and every `req_ready` bit is 0.
- `xfer_cnt` increments on each `out_valid & out_ready` and wraps from all-ones to 0.
- Reset (asynchronous, any time, including mid-transfer):
  - `out_valid` = 0, `out_data` = 0x00, `out_id` = 0, `ptr` = 0, `xfer_cnt` = 0.
  - `req_ready` = 0 while `resetn` = 0.
  - A result pending at reset is discarded and is not counted.

## Timing
- Latency: 1 cycle from the accept edge to `out_valid` = 1 with the result.
- Throughput: 1 result per cycle when `out_ready` is held at 1.
- Fairness: with all requesters continuously valid and no backpressure, each is granted exactly once per `N_REQ` cycles.
- Pointer: a requester that drops valid is skipped with no idle cycle, and the pointer wraps from `N_REQ-1` to 0.
- Backpressure: while FULL and `out_ready` = 0, `ptr` does not move.
- `busy` and `req_ready` are combinational. All other outputs are registered.

## Test plan
- Single request: `req_valid` = 0001 with byte 0x5A for 1 cycle, `out_ready` = 1. Next cycle `out_valid` = 1, `out_data` = 0x80, `out_id` = 0, and `xfer_cnt` goes 0 to 1 after the handshake.
- All valid: `req_valid` = 1111 held, bytes 0x00, 0xFF, 0xC3, 0x5A for requesters 0..3, `out_ready` = 1.
  - `out_id` sequence is 0,1,2,3,0,… with no bubbles.
  - `out_data` sequence is 0x02, 0xE1, 0xFD, 0x80, and so on.
- Backpressure: stage FULL, `out_ready` = 0 for 5 cycles.
  - `req_ready` = 0000; `out_data`, `out_id` and `ptr` stay stable.
  - Raising `out_ready` drains the result and accepts the next requester in the same cycle.
- Pointer skip and wrap: `ptr` = 3, `req_valid` = 0101. Grants go to 0, then 2, then 0.
- Reset mid-operation: assert `resetn` = 0 asynchronously while FULL with `xfer_cnt` = 7.
  - All outputs go to their reset values immediately.
  - After release, the first grant goes to the lowest valid index.
- Counter wrap: with `CNT_W` = 4, perform 17 handshakes; `xfer_cnt` ends at 1.

Source files
------------

// File: rtl/small_comb_logic_arb.sv
// Round-robin arbiter feeding one 8-bit transform unit into a registered,
// ID-tagged output stage with valid/ready backpressure and a handshake counter.
module small_comb_logic_arb #(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ),
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [N_REQ*8-1:0] req_data,
  output logic [N_REQ-1:0]   req_ready,
  output logic               out_valid,
  output logic [7:0]         out_data,
  output logic [ID_W-1:0]    out_id,
  input  logic               out_ready,
  output logic               busy,
  output logic [CNT_W-1:0]   xfer_cnt
);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [ID_W-1:0]   r_ptr;
  logic [7:0]        r_data;
  logic [ID_W-1:0]   r_id;
  logic [CNT_W-1:0]  r_cnt;

  logic [ID_W-1:0]   w_grant;
  logic [ID_W:0]     w_idx;
  logic              w_any;
  logic              w_load_en;
  logic              w_accept;
  logic              w_drain;
  logic [7:0]        w_sel_data;
  logic [7:0]        w_f;
  logic              w_unused;

  assign out_valid = (r_state == ST_FULL);
  assign out_data  = r_data;
  assign out_id    = r_id;
  assign xfer_cnt  = r_cnt;
  assign busy      = out_valid | (|req_valid);

  assign w_load_en = ~out_valid | out_ready;
  assign w_accept  = w_any & w_load_en;
  assign w_drain   = out_valid & out_ready;

  // Walk offsets from far to near so the nearest valid index after ptr wins.
  always_comb begin
    w_grant = '0;
    w_any   = 1'b0;
    w_idx   = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      w_idx = {1'b0, r_ptr} + (ID_W+1)'(k);
      if (w_idx >= (ID_W+1)'(N_REQ)) begin
        w_idx = w_idx - (ID_W+1)'(N_REQ);
      end
      if (req_valid[w_idx[ID_W-1:0]]) begin
        w_grant = w_idx[ID_W-1:0];
        w_any   = 1'b1;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_ready
      assign req_ready[gi] = resetn & w_accept & (w_grant == ID_W'(gi));
    end
  endgenerate

  assign w_sel_data = req_data[{w_grant, 3'b000} +: 8];

  // Bits 5:4 of the input byte do not contribute to the result.
  assign w_unused = ^w_sel_data[5:4];

  assign w_f = {w_sel_data[6] | w_sel_data[7],
                w_sel_data[6] & w_sel_data[7],
                w_sel_data[1:0] + w_sel_data[3:2],
                w_sel_data[1:0] ^ w_sel_data[3:2],
                ~w_sel_data[1],
                w_sel_data[0]};

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_EMPTY: if (w_accept) w_state_next = ST_FULL;
      ST_FULL: begin
        if (w_accept)       w_state_next = ST_FULL;
        else if (out_ready) w_state_next = ST_EMPTY;
      end
      default: w_state_next = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_data <= '0;
      r_id   <= '0;
      r_ptr  <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_accept) begin
        r_data <= w_f;
        r_id   <= w_grant;
        r_ptr  <= (w_grant == ID_W'(N_REQ - 1)) ? '0 : w_grant + 1'b1;
      end
      if (w_drain) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_small_comb_logic_arb.sv
// Self-checking bench: directed scenarios plus random traffic against a
// behavioural model of the arbiter, transform and output stage.
module tb_small_comb_logic_arb;
  localparam int N   = 4;
  localparam int IDW = 2;
  localparam int CW  = 4;

  logic           clk = 1'b0;
  logic           resetn;
  logic [N-1:0]   req_valid;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic           out_valid;
  logic [7:0]     out_data;
  logic [IDW-1:0] out_id;
  logic           out_ready;
  logic           busy;
  logic [CW-1:0]  xfer_cnt;

  int checks = 0;
  int errors = 0;

  bit         m_valid;
  logic [7:0] m_data;
  int         m_id;
  int         m_ptr;
  int         m_cnt;

  always #5 clk = ~clk;

  small_comb_logic_arb #(.N_REQ(N), .ID_W(IDW), .CNT_W(CW)) dut (
    .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .out_valid(out_valid), .out_data(out_data),
    .out_id(out_id), .out_ready(out_ready), .busy(busy), .xfer_cnt(xfer_cnt)
  );

  function automatic logic [7:0] f_ref(input logic [7:0] d);
    int v, lo, hi, b6, b7, r;
    v  = int'(d);
    lo = v % 4;
    hi = (v / 4) % 4;
    b6 = (v / 64) % 2;
    b7 = (v / 128) % 2;
    r  = (v % 2) + (1 - ((v / 2) % 2)) * 2 + (lo ^ hi) * 4 + ((lo + hi) % 4) * 16
       + (b6 & b7) * 64 + (b6 | b7) * 128;
    return r[7:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0;
    m_data  = 8'h00;
    m_id    = 0;
    m_ptr   = 0;
    m_cnt   = 0;
  endtask

  // One clock: drive at posedge+1, check comb outputs, advance model, check regs.
  task automatic cycle(input logic [N-1:0] v, input logic [8*N-1:0] d, input logic ordy);
    int g;
    bit any;
    bit load;
    logic [N-1:0] exp_rdy;
    req_valid = v;
    req_data  = d;
    out_ready = ordy;
    #4;
    any = 1'b0;
    g   = 0;
    for (int k = 0; k < N; k++) begin
      if (!any && v[(m_ptr + k) % N]) begin
        any = 1'b1;
        g   = (m_ptr + k) % N;
      end
    end
    load    = !m_valid || ordy;
    exp_rdy = '0;
    if (any && load) exp_rdy[g] = 1'b1;
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    chk("busy", 32'(busy), 32'(m_valid || (v != '0)));
    @(posedge clk);
    if (m_valid && ordy) begin
      $display("txn id=%0d data=0x%02h cnt=%0d", m_id, m_data, (m_cnt + 1) % 16);
      m_cnt = (m_cnt + 1) % 16;
    end
    if (any && load) begin
      m_data  = f_ref(d[8*g +: 8]);
      m_id    = g;
      m_valid = 1'b1;
      m_ptr   = (g + 1) % N;
    end else if (m_valid && ordy) begin
      m_valid = 1'b0;
    end
    #1;
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    chk("out_data", 32'(out_data), 32'(m_data));
    chk("out_id", 32'(out_id), 32'(m_id));
    chk("xfer_cnt", 32'(xfer_cnt), 32'(m_cnt));
  endtask

  initial begin
    logic [7:0]     held_data;
    logic [IDW-1:0] held_id;
    int             prev_id;
    int             hs;
    logic [8*N-1:0] pat;

    resetn    = 1'b0;
    req_valid = '0;
    req_data  = '0;
    out_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_id", 32'(out_id), 32'd0);
    chk("rst_cnt", 32'(xfer_cnt), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    resetn = 1'b1;

    // Single request
    cycle(4'b0001, 32'h0000_005A, 1'b1);
    chk("single_valid", 32'(out_valid), 32'd1);
    chk("single_data", 32'(out_data), 32'h80);
    chk("single_id", 32'(out_id), 32'd0);
    cycle(4'b0000, 32'h0, 1'b1);
    chk("single_cnt", 32'(xfer_cnt), 32'd1);

    // All requesters valid, no backpressure
    pat = {8'h5A, 8'hC3, 8'hFF, 8'h00};
    cycle(4'b1111, pat, 1'b1);
    prev_id = int'(out_id);
    for (int i = 0; i < 8; i++) begin
      cycle(4'b1111, pat, 1'b1);
      chk("rr_seq", 32'(out_id), 32'((prev_id + 1) % N));
      chk("rr_valid", 32'(out_valid), 32'd1);
      case (out_id)
        2'd0: chk("rr_data", 32'(out_data), 32'h02);
        2'd1: chk("rr_data", 32'(out_data), 32'hE1);
        2'd2: chk("rr_data", 32'(out_data), 32'hFD);
        default: chk("rr_data", 32'(out_data), 32'h80);
      endcase
      prev_id = int'(out_id);
    end

    // Backpressure
    held_data = out_data;
    held_id   = out_id;
    for (int i = 0; i < 5; i++) begin
      cycle(4'b1111, pat, 1'b0);
      chk("bp_ready", 32'(req_ready), 32'd0);
      chk("bp_data", 32'(out_data), 32'(held_data));
      chk("bp_id", 32'(out_id), 32'(held_id));
    end
    cycle(4'b1111, pat, 1'b1);
    chk("bp_resume_valid", 32'(out_valid), 32'd1);
    chk("bp_resume_id", 32'(out_id), 32'((int'(held_id) + 1) % N));

    // Pointer skip and wrap
    cycle(4'b0000, pat, 1'b1);
    cycle(4'b0100, pat, 1'b1);
    cycle(4'b0101, pat, 1'b1);
    chk("skip_g0", 32'(out_id), 32'd0);
    cycle(4'b0101, pat, 1'b1);
    chk("skip_g2", 32'(out_id), 32'd2);
    cycle(4'b0101, pat, 1'b1);
    chk("skip_g0b", 32'(out_id), 32'd0);

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      cycle(4'($urandom_range(0, 15)), 32'($urandom), 1'($urandom_range(0, 3) != 0));
    end

    // Reset while FULL with xfer_cnt = 7
    for (int i = 0; i < 60; i++) begin
      if (m_cnt == 7 && m_valid) break;
      cycle(4'b0001, 32'($urandom), 1'(m_cnt != 7));
    end
    chk("pre_rst_cnt", 32'(xfer_cnt), 32'd7);
    chk("pre_rst_full", 32'(out_valid), 32'd1);
    req_valid = 4'b0110;
    out_ready = 1'b0;
    #2;
    resetn = 1'b0;
    #1;
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_data", 32'(out_data), 32'd0);
    chk("arst_id", 32'(out_id), 32'd0);
    chk("arst_cnt", 32'(xfer_cnt), 32'd0);
    chk("arst_ready", 32'(req_ready), 32'd0);
    chk("arst_busy", 32'(busy), 32'd1);
    model_reset();
    @(posedge clk);
    #1;
    resetn = 1'b1;
    cycle(4'b0110, 32'($urandom), 1'b1);
    chk("post_rst_grant", 32'(out_id), 32'd1);

    // Counter wrap with a 4-bit counter
    hs = 0;
    for (int i = 0; i < 40; i++) begin
      if (hs >= 17) break;
      if (m_valid) hs++;
      cycle(4'b1111, 32'($urandom), 1'b1);
    end
    chk("wrap_hs", 32'(hs), 32'd17);
    chk("wrap_cnt", 32'(xfer_cnt), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
